// File: rtl/prog_loader.sv
// Boot loader: receives a length-prefixed program image over UART (8N1) and writes
// big-endian 32-bit words into instruction memory, holding the core in reset until done.
module prog_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 10
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              uart_rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst_n,
    output logic              load_done,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {LD_LEN_HI, LD_LEN_LO, LD_WORD, LD_DONE} ld_state_t;

    rx_state_t        r_rxState;
    logic             r_sync1, r_sync2, r_sync3;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bitIdx;
    logic [7:0]       r_shift;
    logic [7:0]       r_rxByte;
    logic             r_byteValid;

    ld_state_t        r_ldState;
    logic [15:0]      r_len;
    logic [15:0]      r_wordIdx;
    logic [1:0]       r_byteIdx;
    logic [23:0]      r_word;

    logic [15:0]      w_nextWordIdx;
    logic [31:0]      w_fullWord;

    assign w_nextWordIdx = r_wordIdx + 16'd1;
    assign w_fullWord    = {r_word, r_rxByte};

    // r_sync3 is only the previous synchronized sample for falling-edge detection
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_sync3 <= 1'b1;
        end else begin
            r_sync1 <= uart_rx;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    // The detecting cycle counts as count 0, so START enters at 1 and checks at mid-bit
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rxState   <= RX_IDLE;
            r_cnt       <= '0;
            r_bitIdx    <= '0;
            r_shift     <= '0;
            r_rxByte    <= '0;
            r_byteValid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            r_byteValid <= 1'b0;
            case (r_rxState)
                RX_IDLE: begin
                    if (r_sync3 && !r_sync2) begin
                        r_rxState <= RX_START;
                        r_cnt     <= CNT_W'(1);
                    end
                end
                RX_START: begin
                    if (r_cnt == HALF) begin
                        r_cnt <= '0;
                        if (r_sync2) begin
                            r_rxState <= RX_IDLE;
                        end else begin
                            r_rxState <= RX_DATA;
                            r_bitIdx  <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (r_cnt == FULL) begin
                        r_cnt   <= '0;
                        r_shift <= {r_sync2, r_shift[7:1]};
                        if (r_bitIdx == 3'd7) begin
                            r_rxState <= RX_STOP;
                        end else begin
                            r_bitIdx <= r_bitIdx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (r_cnt == FULL) begin
                        r_cnt     <= '0;
                        r_rxState <= RX_IDLE;
                        if (r_sync2) begin
                            r_byteValid <= 1'b1;
                            r_rxByte    <= r_shift;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_rxState <= RX_IDLE;
            endcase
        end
    end

    // DONE is entered on the same edge as the last write, so the core is released a cycle later
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ldState  <= LD_LEN_HI;
            r_len      <= '0;
            r_wordIdx  <= '0;
            r_byteIdx  <= '0;
            r_word     <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_rst_n <= 1'b0;
            load_done  <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (r_ldState)
                LD_LEN_HI: begin
                    if (r_byteValid) begin
                        r_len[15:8] <= r_rxByte;
                        r_ldState   <= LD_LEN_LO;
                    end
                end
                LD_LEN_LO: begin
                    if (r_byteValid) begin
                        r_len[7:0] <= r_rxByte;
                        r_wordIdx  <= '0;
                        r_byteIdx  <= '0;
                        if ({r_len[15:8], r_rxByte} == 16'd0) begin
                            r_ldState <= LD_DONE;
                        end else begin
                            r_ldState <= LD_WORD;
                        end
                    end
                end
                LD_WORD: begin
                    if (r_byteValid) begin
                        r_word <= w_fullWord[23:0];
                        if (r_byteIdx == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= r_wordIdx[ADDR_W-1:0];
                            imem_wdata <= w_fullWord;
                            r_wordIdx  <= w_nextWordIdx;
                            r_byteIdx  <= '0;
                            if (w_nextWordIdx == r_len) begin
                                r_ldState <= LD_DONE;
                            end
                        end else begin
                            r_byteIdx <= r_byteIdx + 2'd1;
                        end
                    end
                end
                LD_DONE: begin
                    load_done  <= 1'b1;
                    core_rst_n <= 1'b1;
                end
                default: r_ldState <= LD_LEN_HI;
            endcase
        end
    end

endmodule
